alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/seq_multiplier.sv | 56 +++++
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
//   op_t    - 3-bit opcode encoding driven on F
//   state_t - control FSM states
//   flags_t - status flags written alongside every result
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one partial product per step.
// Ports:
//   clk_2   in   clock, rising edge
//   reset   in   synchronous active-high reset
//   load    in   capture A/B, clear accumulator and step counter
//   A, B    in   NBITS-wide unsigned operands
//   step    in   perform one shift-add step
//   product out  2*NBITS accumulator value *including* the current step
//   last    out  the current step is the final (NBITS-th) one
module seq_multiplier #(
    parameter int NBITS = 8
) (
    input  logic               clk_2,
    input  logic               reset,
    input  logic               load,
    input  logic [NBITS-1:0]   A,
    input  logic [NBITS-1:0]   B,
    input  logic               step,
    output logic [2*NBITS-1:0] product,
    output logic               last
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [2*NBITS-1:0] mcand_q;
    logic [NBITS-1:0]   mplier_q;
    logic [2*NBITS-1:0] acc_q;
    logic [2*NBITS-1:0] acc_d;
    logic [CW-1:0]      cnt_q;

    // Product is exposed pre-register so the controller can latch the final
    // value on the same edge that performs the last step.
    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product = acc_d;
    assign last    = (cnt_q == CW'(NBITS - 1));

    always_ff @(posedge clk_2) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{NBITS{1'b0}}, A};
            mplier_q <= B;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake.
// Single-cycle ops complete one edge after start; MUL runs NBITS shift-add
// steps in seq_multiplier. result and flags hold until the next completion.
// Ports:
//   clk_2, reset            clock / synchronous active-high reset
//   start                   request, sampled only in IDLE
//   F                       opcode (op_t)
//   A, B                    operands; shifts use B[SHW-1:0]
//   result                  last completed result
//   zero, neg, carry, ovf   status flags of that result
//   busy                    state != IDLE
//   done                    one-cycle completion pulse
module alu_seq
    import alu_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int SHW   = $clog2(NBITS)
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       F,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    output logic [NBITS-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int MSB = NBITS - 1;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;

    op_t                op;
    logic [NBITS:0]     sum, diff;
    logic [2*NBITS-1:0] shl_w, shr_w;
    logic [NBITS-1:0]   alu_res;
    logic               alu_c, alu_v;

    logic               mul_load, mul_step, mul_last;
    logic [2*NBITS-1:0] mul_prod;

    seq_multiplier #(.NBITS(NBITS)) u_mul (
        .clk_2   (clk_2),
        .reset   (reset),
        .load    (mul_load),
        .A       (A),
        .B       (B),
        .step    (mul_step),
        .product (mul_prod),
        .last    (mul_last)
    );

    assign op       = op_t'(F);
    assign mul_step = (state_q == RUN);

    // Single-cycle datapath. Shifts run in a double-width window so the last
    // bit shifted out lands at a fixed position (and is 0 for s==0).
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} - {1'b0, B};   // diff[NBITS] is the borrow
        shl_w   = {{NBITS{1'b0}}, A} << B[SHW-1:0];
        shr_w   = {A, {NBITS{1'b0}}} >> B[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[NBITS-1:0];
                alu_c   = sum[NBITS];
                alu_v   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[NBITS-1:0];
                alu_c   = diff[NBITS];
                alu_v   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_SHL: begin
                alu_res = shl_w[NBITS-1:0];
                alu_c   = shl_w[NBITS];
            end
            OP_SHR: begin
                alu_res = shr_w[2*NBITS-1:NBITS];
                alu_c   = shr_w[NBITS-1];
            end
            default: ;  // OP_MUL goes through the multiplier
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        mul_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = RUN;
                    end else begin
                        result_d = alu_res;
                        flags_d  = '{zero: ~|alu_res, neg: alu_res[MSB],
                                     carry: alu_c, ovf: alu_v};
                        state_d  = DONE;
                    end
                end
            end
            RUN: begin
                if (mul_last) begin
                    result_d = mul_prod[NBITS-1:0];
                    flags_d  = '{zero: ~|mul_prod[NBITS-1:0],
                                 neg: mul_prod[MSB], carry: 1'b0,
                                 ovf: |mul_prod[2*NBITS-1:NBITS]};
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign zero   = flags_q.zero;
    assign neg    = flags_q.neg;
    assign carry  = flags_q.carry;
    assign ovf    = flags_q.ovf;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    typedef struct {
        logic [7:0] res;
        logic       z, n, c, v;
        int         cyc;
        int         bsy;
    } exp_t;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] F = 3'd0;
    logic [7:0] A = 8'd0, B = 8'd0;
    logic [7:0] result;
    logic       zero, neg, carry, ovf, busy, done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    logic chk_idle_req = 1'b0;
    logic final_req = 1'b0;
    exp_t q[$];

    alu_seq #(.NBITS(8)) dut (
        .clk_2(clk_2), .reset(reset), .start(start), .F(F), .A(A), .B(B),
        .result(result), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf),
        .busy(busy), .done(done)
    );

    always #5 clk_2 = ~clk_2;
    always @(posedge clk_2) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk_2) begin
        exp_t e;
        busy_cnt = busy ? busy_cnt + 1 : 0;
        if (chk_idle_req) begin
            chk("idle_result", int'(result), 0);
            chk("idle_flags", int'({zero, neg, carry, ovf}), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
        end
        if (done) begin
            chk("unexpected_done", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("result", int'(result), int'(e.res));
                chk("flags{z,n,c,v}", int'({zero, neg, carry, ovf}),
                    int'({e.z, e.n, e.c, e.v}));
                chk("done_cycle", cyc, e.cyc);
                chk("busy_len", busy_cnt, e.bsy);
            end
        end
        if (final_req) chk("pending_ops", q.size(), 0);
    end

    // Drive one op (start for one cycle) starting just after a rising edge.
    task automatic issue(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic z, input logic n,
                         input logic c, input logic v, input logic expect_done);
        exp_t e;
        F = f; A = a; B = b; start = 1'b1;
        e.res = res; e.z = z; e.n = n; e.c = c; e.v = v;
        e.cyc = cyc + 1 + ((f == 3'b111) ? 8 : 0);
        e.bsy = (f == 3'b111) ? 9 : 1;
        if (expect_done) q.push_back(e);
        @(posedge clk_2); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && !busy) break;
            @(posedge clk_2); #1;
        end
        @(posedge clk_2); #1;
    endtask

    task automatic idle_check();
        chk_idle_req = 1'b1;
        @(negedge clk_2);
        @(posedge clk_2); #1;
        chk_idle_req = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_2);
        #1 reset = 1'b0;
        idle_check();

        // 1: ADD signed overflow
        issue(3'b000, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 1); wait_idle();
        // boundary: ADD unsigned carry, zero result
        issue(3'b000, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 1); wait_idle();
        // 2: SUB
        issue(3'b001, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0, 1); wait_idle();
        issue(3'b001, 8'h03, 8'h05, 8'hFE, 0, 1, 1, 0, 1); wait_idle();
        // logic ops
        issue(3'b010, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 1); wait_idle();
        issue(3'b011, 8'hF0, 8'h0F, 8'hFF, 0, 1, 0, 0, 1); wait_idle();
        issue(3'b100, 8'hFF, 8'h0F, 8'hF0, 0, 1, 0, 0, 1); wait_idle();
        // 3: shifts
        issue(3'b101, 8'h81, 8'h01, 8'h02, 0, 0, 1, 0, 1); wait_idle();
        issue(3'b110, 8'h01, 8'h01, 8'h00, 1, 0, 1, 0, 1); wait_idle();
        issue(3'b101, 8'h81, 8'h00, 8'h81, 0, 1, 0, 0, 1); wait_idle();
        // 4: MUL
        issue(3'b111, 8'h0C, 8'h0A, 8'h78, 0, 0, 0, 0, 1); wait_idle();
        issue(3'b111, 8'h10, 8'h10, 8'h00, 1, 0, 0, 1, 1); wait_idle();
        issue(3'b111, 8'hFF, 8'hFF, 8'h01, 0, 0, 0, 1, 1); wait_idle();

        // 5: start during RUN is ignored, operand changes have no effect
        issue(3'b111, 8'h0C, 8'h0A, 8'h78, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk_2);
        #1;
        start = 1'b1; F = 3'b000; A = 8'hFF; B = 8'h01;
        @(posedge clk_2); #1;
        start = 1'b0;
        wait_idle();

        // 6: reset mid-RUN aborts the multiply with no done pulse
        issue(3'b111, 8'h0C, 8'h0A, 8'h78, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_2);
        #1 reset = 1'b1;
        @(posedge clk_2); #1;
        reset = 1'b0;
        idle_check();
        repeat (12) @(posedge clk_2);
        #1;
        issue(3'b000, 8'h02, 8'h03, 8'h05, 0, 0, 0, 0, 1); wait_idle();

        final_req = 1'b1;
        @(negedge clk_2);
        @(posedge clk_2); #1;
        final_req = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
